// File: rtl/alsa_sample_fifo.sv
// Stereo {R,L} sample FIFO between the fetch engine and the mixer; one pair leaves per sample_ce.
// Define ALSA_FIFO_FADE_EN to replace hard-zero silence with a per-channel decay toward zero.
module alsa_sample_fifo #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LOW_WATER  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sample_ce,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [31:0]           wr_data,
    output logic                  fetch_req,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underrun,
    input  logic                  underrun_clr,
    output logic [15:0]           alsa_l,
    output logic [15:0]           alsa_r,
    output logic [1:0]            dbg_state_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_HALF = (DEPTH_LOG2 + 1)'(DEPTH / 2);
    localparam logic [DEPTH_LOG2:0] LVL_LOW  = (DEPTH_LOG2 + 1)'(LOW_WATER);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  underrun_q, underrun_d;
    logic                  fetch_req_q, fetch_req_d;
    logic [15:0]           alsa_l_q, alsa_r_q;
    logic [31:0]           mem_q [DEPTH];
    logic                  push, pop, starve;

`ifdef ALSA_FIFO_FADE_EN
    // Snap to zero once the step vanishes so the tail never sticks at +-small values.
    function automatic logic [15:0] fade_step(input logic [15:0] x);
        logic [15:0] step;
        step = $signed(x) >>> 4;
        if (step == 16'h0000 || step == 16'hFFFF) return 16'h0000;
        return x - step;
    endfunction
`endif

    // Write handshake: wr_data is taken on a clk edge where wr_valid && wr_ready; wr_ready
    // looks only at the registered level, so a same-cycle pop never opens a slot.
    always_comb begin
        wr_ready = !reset && (level_q != LVL_FULL) && (state_q != ST_IDLE);
        push     = wr_valid && wr_ready;
        pop      = enable && (state_q == ST_PLAY) && sample_ce && (level_q != '0);
        starve   = enable && (state_q == ST_PLAY) && sample_ce && (level_q == '0);
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (!enable) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_PRIME;
                ST_PRIME: if (level_q >= LVL_HALF) state_d = ST_PLAY;
                ST_PLAY:  if (starve) state_d = ST_PRIME;
                default:  state_d = ST_IDLE;
            endcase
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            level_d = level_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
        end
        underrun_d  = starve || (underrun_q && !underrun_clr);
        fetch_req_d = enable && (level_d < LVL_LOW);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            underrun_q  <= 1'b0;
            fetch_req_q <= 1'b0;
            alsa_l_q    <= '0;
            alsa_r_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            underrun_q  <= underrun_d;
            fetch_req_q <= fetch_req_d;
            // RAM read lands straight in the output register: one cycle after sample_ce.
            if (pop) begin
                alsa_l_q <= mem_q[rd_ptr_q][15:0];
                alsa_r_q <= mem_q[rd_ptr_q][31:16];
            end else if (sample_ce) begin
`ifdef ALSA_FIFO_FADE_EN
                alsa_l_q <= fade_step(alsa_l_q);
                alsa_r_q <= fade_step(alsa_r_q);
`else
                alsa_l_q <= '0;
                alsa_r_q <= '0;
`endif
            end
        end
    end

    assign fetch_req   = fetch_req_q;
    assign level       = level_q;
    assign underrun    = underrun_q;
    assign alsa_l      = alsa_l_q;
    assign alsa_r      = alsa_r_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alsa_sample_fifo.sv
// Bench for alsa_sample_fifo: queue-based reference model plus directed scenarios.
// Output latency: alsa_l/alsa_r carry the popped pair one cycle after the sample_ce edge.
module tb_alsa_sample_fifo;
    logic        clk = 1'b0;
    logic        reset, enable, sample_ce, wr_valid, underrun_clr;
    logic        wr_ready, fetch_req, underrun;
    logic [31:0] wr_data;
    logic [8:0]  level;
    logic [15:0] alsa_l, alsa_r;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO contents, mode (0 idle, 1 priming, 2 playing) and registered outputs.
    logic [31:0] exp_q[$];
    int          m_state;
    logic        m_und, m_fetch;
    logic [15:0] m_l, m_r;

    always #5 clk = ~clk;

    alsa_sample_fifo dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_ce(sample_ce),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .fetch_req(fetch_req), .level(level), .underrun(underrun),
        .underrun_clr(underrun_clr), .alsa_l(alsa_l), .alsa_r(alsa_r),
        .dbg_state_o(dbg_state)
    );

`ifdef ALSA_FIFO_FADE_EN
    function automatic logic [15:0] model_fade(input logic [15:0] x);
        int v, s;
        v = $signed(x);
        s = v >>> 4;
        if (s == 0 || s == -1) return 16'h0000;
        return 16'(v - s);
    endfunction
`endif

    // Advance model with the inputs present at the coming edge, then step past that edge.
    task automatic tick();
        int          sz;
        logic        rdy, do_pop, do_starve;
        logic [31:0] p;
        sz  = exp_q.size();
        rdy = !reset && (sz != 256) && (m_state != 0);
        if (reset) begin
            exp_q.delete();
            m_state = 0; m_und = 1'b0; m_fetch = 1'b0; m_l = '0; m_r = '0;
        end else begin
            do_pop    = enable && m_state == 2 && sample_ce && sz > 0;
            do_starve = enable && m_state == 2 && sample_ce && sz == 0;
            if (do_pop) begin
                p = exp_q.pop_front();
                m_l = p[15:0]; m_r = p[31:16];
            end else if (sample_ce) begin
`ifdef ALSA_FIFO_FADE_EN
                m_l = model_fade(m_l); m_r = model_fade(m_r);
`else
                m_l = 16'h0000; m_r = 16'h0000;
`endif
            end
            if (!enable) begin
                exp_q.delete();
                m_state = 0;
            end else begin
                if (wr_valid && rdy) exp_q.push_back(wr_data);
                if (m_state == 0) m_state = 1;
                else if (m_state == 1 && sz >= 128) m_state = 2;
                else if (m_state == 2 && do_starve) m_state = 1;
            end
            m_und   = do_starve || (m_und && !underrun_clr);
            m_fetch = enable && (exp_q.size() < 64);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n);
        for (int k = 0; k < n; k++) begin
            wr_valid = 1'b1;
            wr_data  = $urandom() | 32'h0001_0001;
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; wr_valid = 1'b1; wr_data = $urandom();
        repeat (3) tick();
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
        checks++; if (level !== 9'd0) begin failures++; $display("FAIL rst_level: got %0d want 0", level); end
        checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL rst_fetch_req: got %b want 0", fetch_req); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun: got %b want 0", underrun); end
        checks++; if ({alsa_r, alsa_l} !== 32'h0) begin failures++; $display("FAIL rst_alsa: got %h want 0", {alsa_r, alsa_l}); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        wr_valid = 1'b0; reset = 1'b0;
        tick();
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rel_wr_ready: got %b want 1", wr_ready); end
        checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL rel_state: got %0d want 1", dbg_state); end
        checks++; if (fetch_req !== 1'b1) begin failures++; $display("FAIL rel_fetch_req: got %b want 1", fetch_req); end
    endtask

    task automatic test_prime_play();
        logic [15:0] li;
        for (int i = 0; i < 128; i++) begin
            li = 16'(i);
            wr_valid = 1'b1; wr_data = {-li, li};
            tick();
        end
        wr_valid = 1'b0;
        checks++; if (level !== 9'd128) begin failures++; $display("FAIL prime_level: got %0d want 128", level); end
        checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL prime_state: got %0d want 1", dbg_state); end
        tick();
        checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL play_entry: got %0d want 2", dbg_state); end
        sample_ce = 1'b1; tick(); sample_ce = 1'b0;
        checks++; if ({alsa_r, alsa_l} !== 32'h0000_0000) begin failures++; $display("FAIL first_pair: got %h want 00000000", {alsa_r, alsa_l}); end
        checks++; if (level !== 9'd127) begin failures++; $display("FAIL first_pop_level: got %0d want 127", level); end
        tick();
        sample_ce = 1'b1; tick(); sample_ce = 1'b0;
        checks++; if ({alsa_r, alsa_l} !== 32'hFFFF_0001) begin failures++; $display("FAIL second_pair: got %h want ffff0001", {alsa_r, alsa_l}); end
    endtask

    task automatic test_fill_full();
        for (int k = 0; k < 200 && exp_q.size() < 256; k++) begin
            wr_valid = 1'b1; wr_data = $urandom(); tick();
        end
        wr_valid = 1'b0;
        checks++; if (level !== 9'd256) begin failures++; $display("FAIL full_level: got %0d want 256", level); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL full_wr_ready: got %b want 0", wr_ready); end
        wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF; sample_ce = 1'b1;
        tick();
        wr_valid = 1'b0; sample_ce = 1'b0;
        checks++; if (level !== 9'd255) begin failures++; $display("FAIL full_push_pop_level: got %0d want 255", level); end
        checks++; if ({alsa_r, alsa_l} !== 32'hFFFE_0002) begin failures++; $display("FAIL full_pop_pair: got %h want fffe0002", {alsa_r, alsa_l}); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL after_full_wr_ready: got %b want 1", wr_ready); end
    endtask

    task automatic test_drain_underrun();
        for (int k = 0; k < 600 && exp_q.size() > 0; k++) begin
            sample_ce = 1'b1; tick(); sample_ce = 1'b0;
            checks++; if ({alsa_r, alsa_l} !== {m_r, m_l}) begin failures++; $display("FAIL drain_pair: got %h want %h", {alsa_r, alsa_l}, {m_r, m_l}); end
            checks++; if (level !== 9'(exp_q.size())) begin failures++; $display("FAIL drain_level: got %0d want %0d", level, exp_q.size()); end
            checks++; if (fetch_req !== m_fetch) begin failures++; $display("FAIL drain_fetch_req: got %b want %b at level %0d", fetch_req, m_fetch, exp_q.size()); end
            tick();
        end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL pre_underrun: got %b want 0", underrun); end
        sample_ce = 1'b1; tick(); sample_ce = 1'b0;
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_set: got %b want 1", underrun); end
        checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL underrun_state: got %0d want 1", dbg_state); end
        checks++; if ({alsa_r, alsa_l} !== {m_r, m_l}) begin failures++; $display("FAIL underrun_silence: got %h want %h", {alsa_r, alsa_l}, {m_r, m_l}); end
`ifndef ALSA_FIFO_FADE_EN
        checks++; if (alsa_l !== 16'h0000) begin failures++; $display("FAIL underrun_alsa_l: got %h want 0000", alsa_l); end
`endif
        tick();
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
        underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_clr: got %b want 0", underrun); end
    endtask

    task automatic test_disable();
        push_n(128);
        tick();
        checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL dis_play: got %0d want 2", dbg_state); end
        for (int k = 0; k < 300 && exp_q.size() > 0; k++) begin
            sample_ce = 1'b1; tick(); sample_ce = 1'b0;
            checks++; if ({alsa_r, alsa_l} !== {m_r, m_l}) begin failures++; $display("FAIL dis_drain_pair: got %h want %h", {alsa_r, alsa_l}, {m_r, m_l}); end
        end
        enable = 1'b0; sample_ce = 1'b1; tick(); sample_ce = 1'b0;
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL dis_priority_underrun: got %b want 0", underrun); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL dis_idle: got %0d want 0", dbg_state); end
        checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL dis_fetch_req: got %b want 0", fetch_req); end
        enable = 1'b1; tick();
        push_n(140);
        checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL dis_mid_play: got %0d want 2", dbg_state); end
        wr_valid = 1'b1; wr_data = $urandom(); enable = 1'b0;
        tick();
        checks++; if (level !== 9'd0) begin failures++; $display("FAIL dis_flush_level: got %0d want 0", level); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL dis_wr_ready: got %b want 0", wr_ready); end
        tick();
        checks++; if (level !== 9'd0) begin failures++; $display("FAIL dis_idle_level: got %0d want 0", level); end
        wr_valid = 1'b0; enable = 1'b1;
        tick();
    endtask

    task automatic test_random_stream();
        int wp[4] = '{12, 4, 8, 1};
        int cp[4] = '{2, 5, 8, 8};
        int len[4] = '{300, 300, 300, 600};
        for (int ph = 0; ph < 4; ph++) begin
            for (int k = 0; k < len[ph]; k++) begin
                wr_valid     = ($urandom_range(0, 15) < wp[ph]);
                wr_data      = $urandom();
                sample_ce    = ($urandom_range(0, 15) < cp[ph]);
                underrun_clr = ($urandom_range(0, 15) == 0);
                tick();
                checks++; if (level !== 9'(exp_q.size())) begin failures++; $display("FAIL rnd_level: got %0d want %0d", level, exp_q.size()); end
                checks++; if (wr_ready !== ((exp_q.size() != 256) && m_state != 0)) begin failures++; $display("FAIL rnd_wr_ready: got %b", wr_ready); end
                checks++; if (fetch_req !== m_fetch) begin failures++; $display("FAIL rnd_fetch_req: got %b want %b", fetch_req, m_fetch); end
                checks++; if (underrun !== m_und) begin failures++; $display("FAIL rnd_underrun: got %b want %b", underrun, m_und); end
                checks++; if ({alsa_r, alsa_l} !== {m_r, m_l}) begin failures++; $display("FAIL rnd_pair: got %h want %h", {alsa_r, alsa_l}, {m_r, m_l}); end
                checks++; if (dbg_state !== 2'(m_state)) begin failures++; $display("FAIL rnd_state: got %0d want %0d", dbg_state, m_state); end
            end
        end
        wr_valid = 1'b0; sample_ce = 1'b0; underrun_clr = 1'b0;
    endtask

    task automatic test_reset_mid_play();
        for (int k = 0; k < 400 && !(m_state == 2 && exp_q.size() >= 130); k++) begin
            wr_valid = 1'b1; wr_data = $urandom() | 32'h0001_0001; tick();
        end
        wr_valid = 1'b0;
        sample_ce = 1'b1; tick(); sample_ce = 1'b0;
        checks++; if ({alsa_r, alsa_l} !== {m_r, m_l}) begin failures++; $display("FAIL rmp_pair: got %h want %h", {alsa_r, alsa_l}, {m_r, m_l}); end
        reset = 1'b1; wr_valid = 1'b1; wr_data = $urandom();
        #1;
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rmp_ready_in_reset: got %b want 0", wr_ready); end
        tick();
        checks++; if (level !== 9'd0) begin failures++; $display("FAIL rmp_level: got %0d want 0", level); end
        checks++; if ({alsa_r, alsa_l} !== 32'h0) begin failures++; $display("FAIL rmp_alsa: got %h want 0", {alsa_r, alsa_l}); end
        checks++; if ({fetch_req, underrun, wr_ready} !== 3'b000) begin failures++; $display("FAIL rmp_flags: got %b want 000", {fetch_req, underrun, wr_ready}); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rmp_state: got %0d want 0", dbg_state); end
        tick();
        checks++; if (level !== 9'd0) begin failures++; $display("FAIL rmp_no_write: got %0d want 0", level); end
        reset = 1'b0; wr_valid = 1'b0;
        tick();
    endtask

`ifdef ALSA_FIFO_FADE_EN
    task automatic test_fade();
        for (int k = 0; k < 128; k++) begin
            wr_valid = 1'b1; wr_data = 32'hC000_4000; tick();
        end
        wr_valid = 1'b0;
        tick();
        for (int k = 0; k < 300 && exp_q.size() > 0; k++) begin
            sample_ce = 1'b1; tick(); sample_ce = 1'b0;
        end
        checks++; if ({alsa_r, alsa_l} !== 32'hC000_4000) begin failures++; $display("FAIL fade_last: got %h want c0004000", {alsa_r, alsa_l}); end
        sample_ce = 1'b1; tick(); sample_ce = 1'b0;
        checks++; if ({alsa_r, alsa_l} !== 32'hC400_3C00) begin failures++; $display("FAIL fade_step1: got %h want c4003c00", {alsa_r, alsa_l}); end
        sample_ce = 1'b1; tick(); sample_ce = 1'b0;
        checks++; if (alsa_l !== 16'h3840) begin failures++; $display("FAIL fade_step2: got %h want 3840", alsa_l); end
        for (int k = 0; k < 300 && (m_l != 0 || m_r != 0); k++) begin
            sample_ce = 1'b1; tick(); sample_ce = 1'b0;
            checks++; if ({alsa_r, alsa_l} !== {m_r, m_l} || alsa_l[15] !== 1'b0) begin failures++; $display("FAIL fade_tail: got %h want %h", {alsa_r, alsa_l}, {m_r, m_l}); end
        end
        checks++; if ({alsa_r, alsa_l} !== 32'h0) begin failures++; $display("FAIL fade_zero: got %h want 0", {alsa_r, alsa_l}); end
    endtask
`endif

    initial begin
        reset = 1'b1; enable = 1'b0; sample_ce = 1'b0; wr_valid = 1'b0;
        wr_data = '0; underrun_clr = 1'b0;
        exp_q.delete();
        m_state = 0; m_und = 1'b0; m_fetch = 1'b0; m_l = '0; m_r = '0;
        test_reset();
        test_prime_play();
        test_fill_full();
        test_drain_underrun();
        test_disable();
        test_random_stream();
        test_reset_mid_play();
`ifdef ALSA_FIFO_FADE_EN
        test_fade();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
